signal_event_capture: RTL and testbench
=======================================

SIGNAL_EVENT_CAPTURE -- requirements
Module: signal_event_capture

Interface
REQ-001 Parameter TS_W, default 16: timestamp width in bits.
REQ-002 Parameter DEPTH, default 8: event FIFO depth, power of two, minimum 2.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  capture enable.
REQ-006 rise_en  input  1  record rising edges of sig_in.
REQ-007 fall_en  input  1  record falling edges of sig_in.
REQ-008 clr  input  1  synchronous clear of overflow and drop_cnt.
REQ-009 sig_in  input  1  monitored signal, synchronous to clk, no synchronizer.
REQ-010 ev_valid  output  1  head event available.
REQ-011 ev_ready  input  1  consumer accepts head event.
REQ-012 ev_rise  output  1  head event type: 1 = rising, 0 = falling.
REQ-013 ev_time  output  TS_W  head event timestamp.
REQ-014 level  output  1  registered copy of sig_in.
REQ-015 overflow  output  1  sticky, set when an event was dropped.
REQ-016 drop_cnt  output  8  count of dropped events, saturating.

Function
REQ-017 Free-running counter ts SHALL increment every clk, wrapping from 2^TS_W-1 to 0, independent of en.
REQ-018 FSM states SHALL be IDLE, ARM and RUN.
REQ-019 IDLE→ARM when en=1; ARM→RUN unconditionally on the next cycle; ARM/RUN→IDLE when en=0.
REQ-020 ARM SHALL load level from sig_in without generating an event, suppressing false edges at enable.
REQ-021 In RUN, an edge SHALL be detected when sig_in≠level; level updates every cycle in ARM and RUN.
REQ-022 A detected edge SHALL be pushed only if its type is enabled (rise_en for 0→1, fall_en for 1→0), tagged with the ts value of the detecting cycle.
REQ-023 Latency: a pushed event SHALL be visible with ev_valid=1 on the cycle after detection when the FIFO was empty.
REQ-024 Pop SHALL occur on any cycle with ev_valid=1 and ev_ready=1; ev_rise and ev_time SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-025 ev_ready with ev_valid=0 SHALL be ignored.
REQ-026 When full with no simultaneous pop, a new event SHALL be dropped, overflow set and drop_cnt incremented, saturating at 255.
REQ-027 When full with a simultaneous pop, the push SHALL succeed and nothing is dropped.
REQ-028 clr SHALL zero overflow and drop_cnt; a drop in the same cycle as clr leaves overflow=1 and drop_cnt=1.
REQ-029 Leaving RUN SHALL retain FIFO contents, which stay readable in IDLE.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, ts=0, FIFO empty, ev_valid=0, ev_rise=0, ev_time=0, level=0, overflow=0, drop_cnt=0.
REQ-031 Reset mid-operation SHALL discard all queued events; the first post-reset capture SHALL pass through ARM.

Structure
REQ-032 Package signal_event_pkg SHALL hold TS_W and DEPTH defaults, the event struct typedef {rise, time}, and the FSM state enum.
REQ-033 Storage SHALL be a sub-module event_fifo: synchronous, first-word-fall-through, full/empty flags, parameterised by the event type and DEPTH.

Verification
REQ-034 Reset release, en=1, rise_en=fall_en=1, sig_in toggled every cycle (as in a posedge-inverting bench), ev_ready=1 → one event per cycle, alternating ev_rise, ev_time increments by 1.
REQ-035 sig_in=1 held while en rises → no event in ARM; first event only on the later 1→0, with ev_rise=0.
REQ-036 ev_ready=0, 10 edges with DEPTH=8 → 8 events held, overflow=1, drop_cnt=2; then clr → drop_cnt=0, and the 8 events drain in order.
REQ-037 FIFO full, edge coincident with pop → no drop, occupancy stays at 8.
REQ-038 TS_W=4, edges at ts=14 and ts=1 after the wrap → ev_time values 14 then 1.
REQ-039 rst_n pulsed low with 3 events queued → ev_valid=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/signal_event_capture_pkg.sv
// Shared types and defaults for the signal event capture block.
package signal_event_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } state_t;

  // "time" is a keyword, so the timestamp field is named tstamp.
  typedef struct packed {
    logic                rise;
    logic [TS_W_DEF-1:0] tstamp;
  } event_t;

endpackage

// File: rtl/signal_event_capture_if.sv
// Event stream handshake: the capture block is the master, the consumer the slave.
interface signal_event_capture_if
  import signal_event_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
);

  logic            ev_valid;
  logic            ev_ready;
  logic            ev_rise;
  logic [TS_W-1:0] ev_time;

  modport master (output ev_valid, ev_rise, ev_time, input ev_ready);
  modport slave  (input ev_valid, ev_rise, ev_time, output ev_ready);

endinterface

// File: rtl/signal_event_capture_event_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO is accepted only with a same-cycle read.
module event_fifo
  import signal_event_pkg::*;
#(
  parameter type T     = event_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  T     wr_data,
  input  logic rd_en,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_wr;
  logic          w_do_rd;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/signal_event_capture.sv
// Timestamps enabled edges of sig_in into an event FIFO, counting events lost to a full FIFO.
module signal_event_capture
  import signal_event_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          rise_en,
  input  logic                          fall_en,
  input  logic                          clr,
  input  logic                          sig_in,
  signal_event_capture_if.master        ev_if,
  output logic                          level,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt
);

  typedef struct packed {
    logic            rise;
    logic [TS_W-1:0] tstamp;
  } ev_t;

  state_t          r_state;
  logic [TS_W-1:0] r_ts;
  logic            r_level;
  logic            r_overflow;
  logic [7:0]      r_drop_cnt;

  ev_t  w_wr_data;
  ev_t  w_head;
  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;

  assign w_push_req = (r_state == ST_RUN) && (sig_in != r_level) && (sig_in ? rise_en : fall_en);
  assign w_pop      = ev_if.ev_ready && !w_empty;
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_wr_data  = {sig_in, r_ts};

  // ARM only samples the line so an already-high sig_in is not reported as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (en) r_state <= ST_ARM;
        ST_ARM:  r_state <= en ? ST_RUN : ST_IDLE;
        ST_RUN:  if (!en) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (r_state != ST_IDLE) r_level <= sig_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  // A drop coinciding with clr survives the clear as a single count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (clr) begin
      r_overflow <= w_drop;
      r_drop_cnt <= {7'd0, w_drop};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  event_fifo #(
    .T     (ev_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_push_req),
    .wr_data (w_wr_data),
    .rd_en   (ev_if.ev_ready),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign ev_if.ev_valid = !w_empty;
  assign ev_if.ev_rise  = w_head.rise;
  assign ev_if.ev_time  = w_head.tstamp;
  assign level          = r_level;
  assign overflow       = r_overflow;
  assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_signal_event_capture.sv
// Directed bench for signal_event_capture with a queue-based reference model checked every cycle.
module tb_signal_event_capture;

  localparam int TS_W  = 4;
  localparam int DEPTH = 8;
  localparam int TS_MOD = 1 << TS_W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rise_en = 1'b0;
  logic       fall_en = 1'b0;
  logic       clr = 1'b0;
  logic       sig_in = 1'b0;
  logic       level;
  logic       overflow;
  logic [7:0] drop_cnt;

  signal_event_capture_if #(.TS_W(TS_W)) ev_if ();

  signal_event_capture #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .clr      (clr),
    .sig_in   (sig_in),
    .ev_if    (ev_if),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit rise;
    int t;
  } mev_t;

  mev_t m_q[$];
  mev_t got[$];
  int   m_ts = 0;
  int   m_en_run = 0;
  int   m_cnt = 0;
  bit   m_level = 1'b0;
  bit   m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: the mode is the number of consecutive cycles en was sampled high
  // (0 idle, 1 sampling, 2+ capturing).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ts = 0; m_en_run = 0; m_cnt = 0; m_level = 1'b0; m_ovf = 1'b0;
    end else begin
      bit pop, want, drop;
      pop  = (m_q.size() != 0) && (ev_if.ev_ready === 1'b1);
      want = (m_en_run >= 2) && (sig_in != m_level) && (sig_in ? rise_en : fall_en);
      drop = 1'b0;
      if (m_en_run >= 1) m_level = sig_in;
      if (pop) void'(m_q.pop_front());
      if (want) begin
        if (m_q.size() < DEPTH) m_q.push_back('{rise: sig_in, t: m_ts});
        else drop = 1'b1;
      end
      if (clr) begin
        m_ovf = drop;
        m_cnt = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      m_ts = (m_ts + 1) % TS_MOD;
      m_en_run = en ? ((m_en_run < 2) ? m_en_run + 1 : 2) : 0;
    end
  end

  always @(negedge clk) begin
    chk("ev_valid", ev_if.ev_valid, m_q.size() != 0);
    chk("level", level, m_level);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_cnt);
    if (m_q.size() != 0) begin
      chk("ev_rise", ev_if.ev_rise, m_q[0].rise);
      chk("ev_time", ev_if.ev_time, m_q[0].t);
    end
    if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1)
      got.push_back('{rise: ev_if.ev_rise, t: int'(ev_if.ev_time)});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle();
    sig_in = ~sig_in;
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ev_valid"}, ev_if.ev_valid, 0);
    chk({tag, "_ev_rise"}, ev_if.ev_rise, 0);
    chk({tag, "_ev_time"}, ev_if.ev_time, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    int k;
    ev_if.ev_ready = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Toggle every cycle with consumer always ready: one event per cycle.
    got.delete();
    en = 1'b1; rise_en = 1'b1; fall_en = 1'b1; ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 12; i++) toggle();
    tick(3);
    chk("stream_count", got.size(), 10);
    if (got.size() == 10) begin
      chk("stream_first_rise", got[0].rise, 1);
      for (int i = 1; i < 10; i++) begin
        chk("stream_alt", got[i].rise, !got[i-1].rise);
        chk("stream_tstep", got[i].t, (got[i-1].t + 1) % TS_MOD);
      end
    end
    en = 1'b0; tick(3);

    // Line already high when enabled: no event until the falling edge.
    got.delete();
    sig_in = 1'b1; en = 1'b1;
    tick(5);
    chk("arm_no_event", got.size(), 0);
    sig_in = 1'b0;
    tick(3);
    chk("arm_fall_count", got.size(), 1);
    if (got.size() == 1) chk("arm_fall_type", got[0].rise, 0);
    en = 1'b0; tick(2);

    // Ten edges with no consumer: eight held, two dropped, then clear and drain.
    got.delete();
    ev_if.ev_ready = 1'b0; en = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) toggle();
    tick(2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_cnt, 2);
    en = 1'b0; clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_flag", overflow, 0);
    chk("clr_drops", drop_cnt, 0);
    ev_if.ev_ready = 1'b1;
    tick(10);
    ev_if.ev_ready = 1'b0;
    chk("drain_count", got.size(), 8);
    if (got.size() == 8) begin
      chk("drain_first_rise", got[0].rise, 1);
      for (int i = 1; i < 8; i++) chk("drain_tstep", got[i].t, (got[i-1].t + 1) % TS_MOD);
    end

    // Full FIFO: push alongside pop succeeds, next push without pop drops during clr.
    got.delete();
    en = 1'b1;
    tick(3);
    for (int i = 0; i < 8; i++) toggle();
    chk("full_valid", ev_if.ev_valid, 1);
    ev_if.ev_ready = 1'b1;
    toggle();
    ev_if.ev_ready = 1'b0;
    chk("full_pop_push_drops", drop_cnt, 0);
    chk("full_pop_push_flag", overflow, 0);
    clr = 1'b1;
    toggle();
    clr = 1'b0;
    chk("clr_drop_flag", overflow, 1);
    chk("clr_drop_cnt", drop_cnt, 1);
    en = 1'b0; tick(1);
    ev_if.ev_ready = 1'b1;
    tick(10);
    ev_if.ev_ready = 1'b0;
    chk("full_total", got.size(), 9);
    if (got.size() == 9) chk("full_last_rise", got[8].rise, 1);
    clr = 1'b1; tick(1); clr = 1'b0;

    // Timestamp wrap: edges detected at ts 14 and ts 1.
    got.delete();
    en = 1'b1; ev_if.ev_ready = 1'b1;
    tick(3);
    k = 0;
    while (m_ts != 14 && k < 40) begin tick(1); k++; end
    chk("wait_ts14", k < 40, 1);
    toggle();
    k = 0;
    while (m_ts != 1 && k < 40) begin tick(1); k++; end
    chk("wait_ts1", k < 40, 1);
    toggle();
    tick(3);
    chk("wrap_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("wrap_t0", got[0].t, 14);
      chk("wrap_t1", got[1].t, 1);
    end

    // Reset with three queued events, then re-enable with the line high.
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) toggle();
    tick(2);
    chk("pre_reset_valid", ev_if.ev_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sig_in = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("post_reset_no_event", ev_if.ev_valid, 0);
    got.delete();
    ev_if.ev_ready = 1'b1; sig_in = 1'b0;
    tick(3);
    chk("post_reset_count", got.size(), 1);
    if (got.size() == 1) chk("post_reset_type", got[0].rise, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
